// File: rtl/zbt_pkg.sv
// Shared constants, pipeline-entry type and parity helper for the ZBT SRAM controller.
package zbt_pkg;

  localparam int DATA_W     = 36;
  localparam int PAR_LSB    = 32;
  localparam int PAR_W      = 4;
  localparam int PIPE_DEPTH = 3;

  typedef struct packed {
    logic              is_write;
    logic              is_read;
    logic [DATA_W-1:0] data;
  } pipe_entry_t;

  typedef enum logic {
    PRIO_RD = 1'b0,
    PRIO_WR = 1'b1
  } prio_t;

  // Even parity per byte lane: bit i is the XOR of byte i.
  function automatic logic [PAR_W-1:0] byte_parity(input logic [PAR_LSB-1:0] d);
    logic [PAR_W-1:0] p;
    for (int i = 0; i < PAR_W; i++) begin
      p[i] = ^d[i*8 +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/zbt_ctrl_if.sv
// Datapath-side request/response bundle for zbt_ctrl.
interface zbt_ctrl_if #(
  parameter int ADDRBITS = 19
);
  import zbt_pkg::*;

  logic                wr_valid;
  logic                wr_ready;
  logic [ADDRBITS-1:0] wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                rd_valid;
  logic                rd_ready;
  logic [ADDRBITS-1:0] rd_addr;
  logic                rd_data_valid;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_perr;
  logic                busy;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready, rd_data_valid, rd_data, rd_perr, busy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready, rd_data_valid, rd_data, rd_perr, busy
  );

endinterface

// File: rtl/zbt_arb.sv
// Two-requester round-robin arbiter; the priority bit flips only on contended grants.
module zbt_arb
  import zbt_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic wr_valid,
  input  logic rd_valid,
  output logic wr_grant,
  output logic rd_grant
);

  prio_t state, state_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= PRIO_RD;
    end else begin
      state <= state_next;
    end
  end

  // Every grant is taken, so a contended cycle always hands priority to the loser.
  always_comb begin
    state_next = state;
    if (wr_valid && rd_valid) begin
      state_next = (state == PRIO_RD) ? PRIO_WR : PRIO_RD;
    end
  end

  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (reset_n) begin
      if (rd_valid && (!wr_valid || state == PRIO_RD)) begin
        rd_grant = 1'b1;
      end else if (wr_valid) begin
        wr_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zbt_ctrl.sv
// Pipelined ZBT SRAM controller: arbitration, 3-slot in-flight pipeline, bus drive and read capture.
// Optional byte parity on bits 35:32 when ZBT_CTRL_PARITY_EN is defined.
module zbt_ctrl
  import zbt_pkg::*;
#(
  parameter int ADDRBITS = 19
) (
  input  logic                clock,
  input  logic                reset_n,
  zbt_ctrl_if.slave           req,
  output logic [ADDRBITS-1:0] sram_addr,
  inout  wire  [DATA_W-1:0]   sram_data,
  output logic                sram_wen,
  output logic                sram_ce
);

  logic                  wr_fire;
  logic                  rd_fire;
  logic                  accept;
  logic [DATA_W-1:0]     wr_word;
  pipe_entry_t           new_entry;
  pipe_entry_t           pipe [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] slot_busy;
  logic                  bus_oe;
  logic                  capture;
  logic                  perr_now;

  zbt_arb u_arb (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_valid (req.wr_valid),
    .rd_valid (req.rd_valid),
    .wr_grant (wr_fire),
    .rd_grant (rd_fire)
  );

  assign req.wr_ready = wr_fire;
  assign req.rd_ready = rd_fire;
  assign accept       = wr_fire | rd_fire;

`ifdef ZBT_CTRL_PARITY_EN
  assign wr_word  = {byte_parity(req.wr_data[PAR_LSB-1:0]), req.wr_data[PAR_LSB-1:0]};
  assign perr_now = |(byte_parity(sram_data[PAR_LSB-1:0]) ^ sram_data[DATA_W-1:PAR_LSB]);
`else
  assign wr_word  = req.wr_data;
  assign perr_now = 1'b0;
`endif

  always_comb begin
    new_entry          = '0;
    new_entry.is_write = wr_fire;
    new_entry.is_read  = rd_fire;
    if (wr_fire) begin
      new_entry.data = wr_word;
    end
  end

  // Slot i holds the command accepted i+1 edges ago; the last slot owns the data cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= new_entry;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_comb begin
    slot_busy = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      slot_busy[i] = pipe[i].is_write | pipe[i].is_read;
    end
  end

  assign req.busy = accept | (|slot_busy);

  // Chip enable stays up until the youngest in-flight command reaches its data edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sram_addr <= '0;
      sram_wen  <= 1'b0;
      sram_ce   <= 1'b0;
    end else begin
      sram_wen <= wr_fire;
      sram_ce  <= accept | (|slot_busy[PIPE_DEPTH-2:0]);
      if (wr_fire) begin
        sram_addr <= req.wr_addr;
      end else if (rd_fire) begin
        sram_addr <= req.rd_addr;
      end
    end
  end

  assign bus_oe    = pipe[PIPE_DEPTH-1].is_write;
  assign sram_data = bus_oe ? pipe[PIPE_DEPTH-1].data : 'z;
  assign capture   = pipe[PIPE_DEPTH-1].is_read;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req.rd_data_valid <= 1'b0;
      req.rd_data       <= '0;
      req.rd_perr       <= 1'b0;
    end else begin
      req.rd_data_valid <= capture;
      if (capture) begin
        req.rd_data <= sram_data;
        req.rd_perr <= perr_now;
      end
    end
  end

endmodule

// File: doc/zbt_ctrl.md
# zbt_ctrl

Pipelined controller for the board's 36-bit ZBT synchronous SRAM, sitting directly upstream of the SRAM device. It accepts independent write and read request streams from the FPGA datapath and arbitrates between them, issuing at most one command per clock. It handles the device's two-cycle address-to-data pipeline on both the shared bidirectional data bus and the returned read data, so the datapath never sees SRAM timing.

## Interface
- ADDRBITS, 19, SRAM word-address width
- clock  in  1  single system clock; SRAM runs on the same clock
- reset_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request present
- wr_ready  out  1  write request granted this cycle (combinational)
- wr_addr  in  ADDRBITS  write word address
- wr_data  in  36  write data
- rd_valid  in  1  read request present
- rd_ready  out  1  read request granted this cycle (combinational)
- rd_addr  in  ADDRBITS  read word address
- rd_data_valid  out  1  one-cycle strobe, rd_data holds returned word
- rd_data  out  36  returned read word
- rd_perr  out  1  parity error on current rd_data (ZBT_CTRL_PARITY_EN only, else 0)
- busy  out  1  a command is issued or in flight
- sram_addr  out  ADDRBITS  registered SRAM address
- sram_data  inout  36  SRAM data bus
- sram_wen  out  1  registered write enable, 1 = write
- sram_ce  out  1  registered chip enable

## Operation
- Transfer happens on a clock edge where valid & ready are both high. At most one of wr_ready and rd_ready is high in any cycle.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: round-robin. The priority bit flips after every contended grant. After reset, read has priority.
- An accepted command is registered onto sram_addr/sram_wen, with sram_ce=1.
- When no command is accepted in a cycle:
  - sram_wen=0.
  - sram_addr holds its previous value.
  - sram_ce=1 while any write or read is in flight, otherwise 0.
- Idle cycles with sram_ce=1 act as dummy reads. Their bus data is ignored; no rd_data_valid is produced.
- In-flight tracking: a 3-stage shift pipeline, one {is_write, is_read, data[35:0]} entry per issue slot.
  - Write data is carried in the pipeline.
  - Data is driven onto sram_data only during its single data cycle. The bus is Z at all other times.
- Read data is sampled from sram_data in its data cycle and registered to rd_data with a one-cycle rd_data_valid.
- The SRAM needs no bus turnaround: back-to-back write/read/write at full rate is legal, and each slot owns exactly one data cycle.
- busy = accepted-this-cycle OR any pipeline stage occupied.
- Reset (asserted at any time, including mid-operation):
  - Pipeline cleared and sram_data released to Z immediately.
  - In-flight reads produce no strobe.
  - In-flight writes are lost.

## Timing
- Reset values: wr_ready=0, rd_ready=0, rd_data_valid=0, rd_data=0, rd_perr=0, busy=0, sram_addr=0, sram_wen=0, sram_ce=0, sram_data=Z.
- Write accepted at edge E:
  - sram_wen=1 during (E, E+1]; the SRAM samples the command at E+1.
  - Controller drives sram_data during [E+2, E+3).
  - The SRAM latches the data at E+3.
- Read accepted at edge E:
  - The SRAM drives the bus during [E+2, E+3).
  - Controller samples at E+3.
  - rd_data_valid=1 during [E+3, E+4). Fixed latency 3 clocks.
- sram_ce stays 1 through the E+3 edge of every in-flight command.
- Throughput: one command per clock sustained. Reads return in issue order.

## Configuration
- ZBT_CTRL_PARITY_EN defined:
  - Bits 35:32 of each written word are replaced by even parity of bytes 3..0 of wr_data[31:0].
  - On read, parity is recomputed. rd_perr=1 with rd_data_valid if any byte mismatches.
  - rd_data[35:32] returns the stored parity.
- ZBT_CTRL_PARITY_EN undefined: all 36 bits pass through unchanged and rd_perr is tied 0.

## Structure
- Shared package zbt_pkg holds:
  - SRAM data width (36) and parity-lane constants.
  - The pipeline-entry struct typedef {is_write, is_read, data}.
  - Pipeline depth constant (3).
- One sub-module: zbt_arb, the two-requester round-robin arbiter with its priority flop. Pipeline, bus drive and parity stay in zbt_ctrl.

## Test plan
- Reset, then single write of 36'h9_1234_5678 to addr 5, then read of addr 5 → rd_data_valid exactly 3 clocks after read acceptance, rd_data=36'h9_1234_5678 (parity off).
- Alternating write/read every clock to addrs 0..15, write data = addr*3 → each read returns the value written to that addr. No bus contention (no X on sram_data). sram_ce never low with a write in flight.
- Both valid continuously for 8 cycles → grants alternate R,W,R,W…, 4 each.
- Idle after traffic → sram_ce falls 3 clocks after the last command. busy falls in the same cycle. sram_data=Z.
- reset_n asserted one clock after a read is accepted → outputs return to reset values immediately. No rd_data_valid follows.
- ZBT_CTRL_PARITY_EN: write 32'hFF00_0001, corrupt bit 0 in the SRAM model, read back → rd_perr=1 with rd_data_valid; uncorrupted read gives rd_perr=0, rd_data[35:32]=4'b0001.
